// File: rtl/program_counter_unit.sv
// ============================================================================
// Module   : program_counter_unit
// Brief    : 16-bit program counter with byte loads, increment and relative
//            branches that take a second cycle to fix PCH on a page cross.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module program_counter_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pcIncrement,
  input  logic       pcLoadLow,
  input  logic       pcLoadHigh,
  input  logic [7:0] loadData,
  input  logic       branchStart,
  input  logic [7:0] branchOffset,
  output logic [7:0] pcLowOutput,
  output logic [7:0] pcHighOutput,
  output logic       branchBusy
);

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    FIX_HIGH = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] pcl_q, pcl_d;
  logic [7:0] pch_q, pch_d;
  logic       fix_dir_q, fix_dir_d;
  logic [8:0] branch_sum;

  always_comb begin
    state_d    = state_q;
    pcl_d      = pcl_q;
    pch_d      = pch_q;
    fix_dir_d  = fix_dir_q;
    branch_sum = {1'b0, pcl_q} + {1'b0, branchOffset};

    case (state_q)
      IDLE: begin
        if (branchStart) begin
          pcl_d = branch_sum[7:0];
          // Carry out with a forward offset, or no carry with a backward
          // offset, means the target lies on the adjacent page.
          if (!branchOffset[7] && branch_sum[8]) begin
            state_d   = FIX_HIGH;
            fix_dir_d = 1'b0;
          end else if (branchOffset[7] && !branch_sum[8]) begin
            state_d   = FIX_HIGH;
            fix_dir_d = 1'b1;
          end
        end else if (pcLoadLow || pcLoadHigh) begin
          if (pcLoadLow)  pcl_d = loadData;
          if (pcLoadHigh) pch_d = loadData;
        end else if (pcIncrement) begin
          {pch_d, pcl_d} = {pch_q, pcl_q} + 16'd1;
        end
      end
      FIX_HIGH: begin
        pch_d   = fix_dir_q ? (pch_q - 8'd1) : (pch_q + 8'd1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pcl_q     <= RESET_PC[7:0];
      pch_q     <= RESET_PC[15:8];
      fix_dir_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pcl_q     <= pcl_d;
      pch_q     <= pch_d;
      fix_dir_q <= fix_dir_d;
    end
  end

  assign pcLowOutput  = pcl_q;
  assign pcHighOutput = pch_q;
  assign branchBusy   = (state_q == FIX_HIGH);

endmodule

`default_nettype wire

// File: tb/tb_program_counter_unit.sv
// ============================================================================
// Module   : tb_program_counter_unit
// Brief    : Scoreboard bench for program_counter_unit (RESET_PC = 16'hFFFC).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_program_counter_unit;

  localparam logic [15:0] RESET_PC = 16'hFFFC;

  logic       clk;
  logic       rst;
  logic       pcIncrement;
  logic       pcLoadLow;
  logic       pcLoadHigh;
  logic [7:0] loadData;
  logic       branchStart;
  logic [7:0] branchOffset;
  logic [7:0] pcLowOutput;
  logic [7:0] pcHighOutput;
  logic       branchBusy;

  program_counter_unit #(.RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .rst         (rst),
    .pcIncrement (pcIncrement),
    .pcLoadLow   (pcLoadLow),
    .pcLoadHigh  (pcLoadHigh),
    .loadData    (loadData),
    .branchStart (branchStart),
    .branchOffset(branchOffset),
    .pcLowOutput (pcLowOutput),
    .pcHighOutput(pcHighOutput),
    .branchBusy  (branchBusy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected value is {busy, PCH, PCL}.
  typedef struct {
    string       tag;
    logic [16:0] exp;
  } sb_entry_t;

  sb_entry_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [16:0] observed();
    return {branchBusy, pcHighOutput, pcLowOutput};
  endfunction

  // Drive one cycle of commands, push the expectation, then compare after the edge.
  task automatic drive(input logic inc, input logic ll, input logic lh,
                       input logic [7:0] data, input logic br, input logic [7:0] off,
                       input string tag, input logic [16:0] exp);
    sb_entry_t e;
    pcIncrement  = inc;
    pcLoadLow    = ll;
    pcLoadHigh   = lh;
    loadData     = data;
    branchStart  = br;
    branchOffset = off;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
    @(posedge clk);
    #1;
    pcIncrement  = 1'b0;
    pcLoadLow    = 1'b0;
    pcLoadHigh   = 1'b0;
    branchStart  = 1'b0;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check(e.tag, {15'd0, observed()}, {15'd0, e.exp});
    end
  endtask

  task automatic idle(input string tag, input logic [16:0] exp);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, tag, exp);
  endtask

  task automatic load_both(input logic [7:0] d, input string tag, input logic [16:0] exp);
    drive(1'b0, 1'b1, 1'b1, d, 1'b0, 8'h00, tag, exp);
  endtask

  task automatic load_low(input logic [7:0] d, input string tag, input logic [16:0] exp);
    drive(1'b0, 1'b1, 1'b0, d, 1'b0, 8'h00, tag, exp);
  endtask

  task automatic load_high(input logic [7:0] d, input string tag, input logic [16:0] exp);
    drive(1'b0, 1'b0, 1'b1, d, 1'b0, 8'h00, tag, exp);
  endtask

  task automatic incr(input string tag, input logic [16:0] exp);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, tag, exp);
  endtask

  task automatic branch(input logic [7:0] off, input string tag, input logic [16:0] exp);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, off, tag, exp);
  endtask

  // Asynchronous reset pulse placed mid-cycle, checked before the next edge.
  task automatic async_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    check(tag, {15'd0, observed()}, {15'd0, 1'b0, RESET_PC});
    #1 rst = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    pcIncrement  = 1'b0;
    pcLoadLow    = 1'b0;
    pcLoadHigh   = 1'b0;
    loadData     = 8'h00;
    branchStart  = 1'b0;
    branchOffset = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("reset_value", {15'd0, observed()}, {15'd0, 1'b0, RESET_PC});
    rst = 1'b0;

    idle("hold_after_reset", {1'b0, 16'hFFFC});
    incr("inc_fffd", {1'b0, 16'hFFFD});
    incr("inc_fffe", {1'b0, 16'hFFFE});
    incr("inc_ffff", {1'b0, 16'hFFFF});
    incr("inc_wrap", {1'b0, 16'h0000});

    load_low (8'hFF, "load_low_ff",  {1'b0, 16'h00FF});
    load_high(8'h12, "load_high_12", {1'b0, 16'h12FF});
    incr("inc_carry_1300", {1'b0, 16'h1300});
    load_both(8'hFF, "load_ffff", {1'b0, 16'hFFFF});
    incr("inc_ffff_wrap", {1'b0, 16'h0000});
    drive(1'b1, 1'b1, 1'b1, 8'hAB, 1'b0, 8'h00, "load_beats_inc", {1'b0, 16'hABAB});
    drive(1'b1, 1'b1, 1'b0, 8'h34, 1'b0, 8'h00, "load_low_beats_inc", {1'b0, 16'hAB34});

    // Forward branch, same page
    load_both(8'h10, "setup_1010", {1'b0, 16'h1010});
    branch(8'h20, "fwd_nocross", {1'b0, 16'h1030});
    idle("fwd_nocross_settle", {1'b0, 16'h1030});

    // Forward branch, page cross
    load_low(8'hF0, "setup_10f0", {1'b0, 16'h10F0});
    branch(8'h20, "fwd_cross_e1", {1'b1, 16'h1010});
    idle("fwd_cross_e2", {1'b0, 16'h1110});

    // Backward branch, page cross
    load_both(8'h10, "setup_1010b", {1'b0, 16'h1010});
    load_low(8'h05, "setup_1005", {1'b0, 16'h1005});
    branch(8'hF0, "bwd_cross_e1", {1'b1, 16'h10F5});
    idle("bwd_cross_e2", {1'b0, 16'h0FF5});

    // Backward branch, same page
    load_low (8'h20, "setup_0f20", {1'b0, 16'h0F20});
    load_high(8'h10, "setup_1020", {1'b0, 16'h1020});
    branch(8'hF0, "bwd_nocross", {1'b0, 16'h1010});

    // Backward branch wrapping PCH
    load_both(8'h00, "setup_0000", {1'b0, 16'h0000});
    load_low(8'h05, "setup_0005", {1'b0, 16'h0005});
    branch(8'hF0, "bwd_wrap_e1", {1'b1, 16'h00F5});
    idle("bwd_wrap_e2", {1'b0, 16'hFFF5});

    // Commands during FIX_HIGH are ignored
    load_both(8'h10, "setup_1010c", {1'b0, 16'h1010});
    load_low(8'hF0, "setup_10f0c", {1'b0, 16'h10F0});
    branch(8'h20, "ign_e1", {1'b1, 16'h1010});
    drive(1'b1, 1'b1, 1'b1, 8'h55, 1'b1, 8'h20, "ign_cmds_in_fix", {1'b0, 16'h1110});
    incr("inc_after_fix", {1'b0, 16'h1111});

    // Reset during FIX_HIGH aborts the fix
    load_low(8'hF0, "setup_11f0", {1'b0, 16'h11F0});
    branch(8'h20, "abort_e1", {1'b1, 16'h1110});
    async_reset("abort_reset");
    idle("abort_idle_hold", {1'b0, 16'hFFFC});
    branch(8'h02, "post_abort_nocross", {1'b0, 16'hFFFE});
    branch(8'h10, "post_abort_cross_e1", {1'b1, 16'hFF0E});
    idle("post_abort_cross_e2", {1'b0, 16'h000E});

    check("scoreboard_drained", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
